stack_unit: RTL and testbench

Hardware LIFO stack that serves the push/pop requests issued by the decode stage for stack instructions. Decode drives push with write data, or pop. The unit returns the popped word one cycle later, to be muxed into the writeback path. It keeps its occupancy state and flags stack misuse (overflow/underflow) to the core as sticky error bits.

---
 rtl/stack_unit.sv | 162 ++++++++++++++++
 tb/tb_stack_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//   LIFO stack that serves the push/pop requests from the decode stage for stack
//   instructions. The popped word is returned one cycle after the pop request,
//   registered, so it can be muxed into writeback. Overflow and underflow are
//   reported as sticky error bits until clr_err clears them.
//
//   Optional feature (macro STACK_PEEK_EN):
//     When defined, the top_data output combinationally shows the current top
//     of stack (0 when the stack is empty).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   push       in   push request
//   pop        in   pop request
//   push_data  in   word to push            [DATA_WIDTH]
//   clr_err    in   synchronous clear of the sticky error flags
//   pop_data   out  popped word, registered [DATA_WIDTH]
//   pop_valid  out  one-cycle pulse, pop_data is valid
//   empty      out  count == 0
//   full       out  count == DEPTH
//   count      out  occupancy 0..DEPTH      [PTR_WIDTH+1]
//   overflow   out  sticky: push while full
//   underflow  out  sticky: pop while empty
//   top_data   out  top-of-stack peek       [DATA_WIDTH]  (STACK_PEEK_EN only)
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_WIDTH:0]    count,
`ifdef STACK_PEEK_EN
  output logic [DATA_WIDTH-1:0] top_data,
`endif
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   ONE_COUNT  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] ONE_PTR    = PTR_WIDTH'(1);

  // Storage has no reset: contents are meaningless until written.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0]  top_idx;
  logic [DATA_WIDTH-1:0] top_word;

  // Decoded request classes
  logic push_only_ok;   // push into a non-full stack
  logic pop_only_ok;    // pop from a non-empty stack
  logic swap;           // push+pop on a non-empty stack: replace the top
  logic bypass;         // push+pop on an empty stack: forward push_data
  logic ovf_event;
  logic udf_event;

  logic                  wr_en;
  logic [PTR_WIDTH-1:0]  wr_idx;

  logic [PTR_WIDTH:0]    count_next;
  logic [DATA_WIDTH-1:0] pop_data_next;
  logic                  pop_valid_next;
  logic                  overflow_next;
  logic                  underflow_next;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // The low PTR_WIDTH bits of count-1 address the top entry; for a full stack
  // the low bits of count are 0 and the subtraction wraps to DEPTH-1 as wanted.
  assign top_idx  = count[PTR_WIDTH-1:0] - ONE_PTR;
  assign top_word = mem[top_idx];

  assign push_only_ok = push && !pop && !full;
  assign pop_only_ok  = pop && !push && !empty;
  assign swap         = push && pop && !empty;
  assign bypass       = push && pop && empty;
  assign ovf_event    = push && !pop && full;
  assign udf_event    = pop && !push && empty;

  always_comb begin
    wr_en          = 1'b0;
    wr_idx         = count[PTR_WIDTH-1:0];
    count_next     = count;
    pop_data_next  = pop_data;
    pop_valid_next = 1'b0;
    overflow_next  = overflow;
    underflow_next = underflow;

    if (push_only_ok) begin
      wr_en      = 1'b1;
      wr_idx     = count[PTR_WIDTH-1:0];
      count_next = count + ONE_COUNT;
    end

    if (pop_only_ok) begin
      pop_data_next  = top_word;
      pop_valid_next = 1'b1;
      count_next     = count - ONE_COUNT;
    end

    if (swap) begin
      // Old top is read out while the new word overwrites the same slot.
      wr_en          = 1'b1;
      wr_idx         = top_idx;
      pop_data_next  = top_word;
      pop_valid_next = 1'b1;
    end

    if (bypass) begin
      pop_data_next  = push_data;
      pop_valid_next = 1'b1;
    end

    // A new error event takes priority over a clear in the same cycle.
    if (clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (ovf_event) overflow_next  = 1'b1;
    if (udf_event) underflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      pop_data  <= pop_data_next;
      pop_valid <= pop_valid_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

`ifdef STACK_PEEK_EN
  assign top_data = empty ? '0 : top_word;
`endif

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;
  logic          clr_err;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          empty;
  logic          full;
  logic [PW:0]   count;
  logic          overflow;
  logic          underflow;
`ifdef STACK_PEEK_EN
  logic [DW-1:0] top_data;
`endif

  int tests;
  int fails;

  stack_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clr_err   (clr_err),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
`ifdef STACK_PEEK_EN
    .top_data  (top_data),
`endif
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (queue of words) ----------------
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_pd;
  logic          m_pv;
  logic          m_ovf;
  logic          m_udf;

  task automatic model_reset();
    mq.delete();
    m_pd  = '0;
    m_pv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic c,
                            input logic [DW-1:0] d);
    logic ovf_set;
    logic udf_set;
    ovf_set = p && !q && (mq.size() == DEPTH);
    udf_set = q && !p && (mq.size() == 0);
    m_pv = 1'b0;
    if (p && q) begin
      m_pv = 1'b1;
      if (mq.size() == 0) begin
        m_pd = d;
      end else begin
        m_pd = mq[mq.size()-1];
        mq[mq.size()-1] = d;
      end
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
    end else if (q) begin
      if (mq.size() > 0) begin
        m_pd = mq.pop_back();
        m_pv = 1'b1;
      end
    end
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    if (udf_set) m_udf = 1'b1;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request for one clock, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
    push = p; pop = q; clr_err = c; push_data = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pop_valid"}, 64'(pop_valid), 64'(m_pv));
    check({tag, "_pop_data"},  64'(pop_data),  64'(m_pd));
    check({tag, "_count"},     64'(count),     64'(mq.size()));
    check({tag, "_empty"},     64'(empty),     64'(mq.size() == 0));
    check({tag, "_full"},      64'(full),      64'(mq.size() == DEPTH));
    check({tag, "_overflow"},  64'(overflow),  64'(m_ovf));
    check({tag, "_underflow"}, 64'(underflow), 64'(m_udf));
`ifdef STACK_PEEK_EN
    check({tag, "_top_data"},  64'(top_data),  (mq.size() == 0) ? 64'd0 : 64'(mq[mq.size()-1]));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          push;
    logic          pop;
    logic          clr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_pd;
    logic          exp_pv;
    int            exp_cnt;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;

    //          push  pop   clr   data          exp_pd        pv    cnt ovf   udf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h11111111, 32'h00000000, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h22222222, 32'h00000000, 1'b0, 2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h33333333, 32'h00000000, 1'b0, 3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h33333333, 1'b1, 2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h22222222, 1'b1, 1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h11111111, 1'b1, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h11111111, 1'b0, 0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h11111111, 1'b0, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h00001234, 32'h11111111, 1'b0, 1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000AAAA, 32'h11111111, 1'b0, 2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0000BBBB, 32'h0000AAAA, 1'b1, 2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000BBBB, 1'b1, 1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h00001234, 1'b1, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h00000005, 32'h00000005, 1'b1, 0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00000005, 1'b0, 0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h00000005, 1'b0, 0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h00000005, 1'b0, 0, 1'b0, 1'b0};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",     64'(count),     64'd0);
    check("rst_pop_data",  64'(pop_data),  64'd0);
    check("rst_pop_valid", 64'(pop_valid), 64'd0);
    check("rst_empty",     64'(empty),     64'd1);
    check("rst_full",      64'(full),      64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    rst = 1'b0;

    // ---- table-driven directed vectors ----
    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
      check($sformatf("vec%0d_pop_data", i),  64'(pop_data),  64'(vecs[i].exp_pd));
      check($sformatf("vec%0d_pop_valid", i), 64'(pop_valid), 64'(vecs[i].exp_pv));
      check($sformatf("vec%0d_count", i),     64'(count),     64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_empty", i),     64'(empty),     64'(vecs[i].exp_cnt == 0));
      check($sformatf("vec%0d_overflow", i),  64'(overflow),  64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_underflow", i), 64'(underflow), 64'(vecs[i].exp_udf));
      $display("[TB] vec %0d push=%0b pop=%0b clr=%0b data=%h -> pop_data=%h pv=%0b count=%0d",
               i, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data, pop_data, pop_valid, count);
    end

    // ---- underflow straight after reset ----
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("udf_flag",      64'(underflow), 64'd1);
    check("udf_pop_valid", 64'(pop_valid), 64'd0);
    check("udf_pop_data",  64'(pop_data),  64'd0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("udf_cleared",   64'(underflow), 64'd0);
    $display("[TB] underflow after reset, then clr_err");

    // ---- fill to full, overflow, pop, swap on full ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 32'(i));
    check("fill_count", 64'(count), 64'd16);
    check("fill_full",  64'(full),  64'd1);
    check("fill_ovf",   64'(overflow), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'hDEAD);
    check("ovf_flag",   64'(overflow), 64'd1);
    check("ovf_count",  64'(count),    64'd16);
    check("ovf_full",   64'(full),     64'd1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("ovf_pop_data",  64'(pop_data),  64'hF);
    check("ovf_pop_valid", 64'(pop_valid), 64'd1);
    check("ovf_pop_count", 64'(count),     64'd15);
    check("ovf_sticky",    64'(overflow),  64'd1);
    cycle(1'b1, 1'b0, 1'b1, 32'h99);
    check("refill_full",   64'(full),     64'd1);
    check("refill_clr",    64'(overflow), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h77);
    check("fullswap_pop_data", 64'(pop_data), 64'h99);
    check("fullswap_count",    64'(count),    64'd16);
    check("fullswap_no_ovf",   64'(overflow), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("fullswap_new_top",  64'(pop_data), 64'h77);
    $display("[TB] fill/overflow/full-swap sequence done");

`ifdef STACK_PEEK_EN
    // ---- peek port ----
    do_reset();
    check("peek_empty0", 64'(top_data), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'h1234);
    check("peek_top",    64'(top_data), 64'h1234);
    check("peek_count",  64'(count),    64'd1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("peek_empty1", 64'(top_data), 64'd0);
    $display("[TB] peek sequence done");
`endif

    // ---- async reset while a pop result is showing ----
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'hC0DE0000 + 32'(i));
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("arst_pre_valid", 64'(pop_valid), 64'd1);
    check("arst_pre_data",  64'(pop_data),  64'hC0DE0002);
    pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(pop_valid), 64'd0);
    check("arst_data",  64'(pop_data),  64'd0);
    check("arst_count", 64'(count),     64'd0);
    check("arst_empty", 64'(empty),     64'd1);
    pop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      check($sformatf("arst_after%0d_valid", i), 64'(pop_valid), 64'd0);
      check($sformatf("arst_after%0d_count", i), 64'(count),     64'd0);
    end
    $display("[TB] async reset mid-operation done");

    // ---- randomized run against the queue model ----
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic p, q, c;
      logic [DW-1:0] d;
      int push_pct;
      // Alternate push-heavy and pop-heavy phases so both full and empty are hit.
      push_pct = ((i / 150) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(0, 99) < push_pct);
      q = ($urandom_range(0, 99) < (100 - push_pct));
      c = ($urandom_range(0, 99) < 8);
      d = $urandom;
      cycle(p, q, c, d);
      model_step(p, q, c, d);
      check_model($sformatf("rnd%0d", i));
      $display("[TB] rnd %0d push=%0b pop=%0b clr=%0b data=%h -> pop_data=%h pv=%0b count=%0d ovf=%0b udf=%0b",
               i, p, q, c, d, pop_data, pop_valid, count, overflow, underflow);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
